// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer for the writeback stage.
// Executes CSRRW/CSRRS/CSRRC and MRET and takes timer/external interrupts.
// It also emits registered redirect pulses for the fetch PC mux and the flush logic.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic        csr_we,
  input  logic        csr_re,
  input  logic        is_mret,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] pc_wb,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] csr_rdata,
  output logic        trap_taken,
  output logic        mret_taken,
  output logic [31:0] epc_evec
);

  // Synchronizer depth is clamped so a mis-set parameter never yields a single flop.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;

  localparam logic [3:0] CAUSE_EXT = 4'd11;
  localparam logic [3:0] CAUSE_TMR = 4'd7;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Read-modify-write result for the three CSR instruction kinds (funct3[1:0]).
  function automatic logic [31:0] csr_alu(input logic [1:0]  op,
                                          input logic [31:0] old_val,
                                          input logic [31:0] wval);
    logic [31:0] res;
    case (op)
      2'b01:   res = wval;
      2'b10:   res = old_val | wval;
      2'b11:   res = old_val & ~wval;
      default: res = old_val;
    endcase
    return res;
  endfunction

  // Only direct (0) and vectored (1) modes are legal; reserved modes collapse to direct.
  function automatic logic [31:0] mtvec_legalize(input logic [31:0] v);
    logic [1:0] mode;
    case (v[1:0])
      2'b00:   mode = 2'b00;
      2'b01:   mode = 2'b01;
      default: mode = 2'b00;
    endcase
    return {v[31:2], mode};
  endfunction

  // Architectural state
  state_t        state_r;
  state_t        state_nxt_s;
  logic          run_s;
  logic          mstatus_mie_r;
  logic          mstatus_mpie_r;
  logic          mie_mtie_r;
  logic          mie_meie_r;
  logic [31:0]   mtvec_r;
  logic [31:0]   mscratch_r;
  logic [31:0]   mepc_r;
  logic [31:0]   mcause_r;
  logic [63:0]   mcycle_r;
  logic [SYNC_N-1:0] tsync_r;
  logic [SYNC_N-1:0] esync_r;
  logic          trap_taken_r;
  logic          mret_taken_r;
  logic [31:0]   epc_evec_r;

  // Combinational decisions
  logic          mtip_s;
  logic          meip_s;
  logic [31:0]   csr_old_s;
  logic [31:0]   csr_new_s;
  logic          write_en_s;
  logic          commit_s;
  logic          pend_e_s;
  logic          pend_t_s;
  logic          trap_s;
  logic          mret_s;
  logic [3:0]    cause_s;
  logic [31:0]   evec_s;
  logic          unused_bits_s;

  // funct3[2] only selects the immediate operand, which the decoder already muxed in.
  assign unused_bits_s = ^{csr_op[2], pc_wb[1:0]};

  assign mtip_s = tsync_r[SYNC_N-1];
  assign meip_s = esync_r[SYNC_N-1];

  // Interrupt level synchronizers; keep shifting in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tsync_r <= {SYNC_N{1'b0}};
      esync_r <= {SYNC_N{1'b0}};
    end else begin
      tsync_r <= {tsync_r[SYNC_N-2:0], timer_irq};
      esync_r <= {esync_r[SYNC_N-2:0], ext_irq};
    end
  end

  // Select the current (pre-write) value of the addressed CSR.
  always_comb begin
    csr_old_s = 32'h0000_0000;
    case (csr_addr)
      ADDR_MSTATUS:  csr_old_s = {19'd0, 2'b11, 3'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};
      ADDR_MIE:      csr_old_s = {20'd0, mie_meie_r, 3'd0, mie_mtie_r, 7'd0};
      ADDR_MTVEC:    csr_old_s = mtvec_r;
      ADDR_MSCRATCH: csr_old_s = mscratch_r;
      ADDR_MEPC:     csr_old_s = mepc_r;
      ADDR_MCAUSE:   csr_old_s = mcause_r;
      ADDR_MIP:      csr_old_s = {20'd0, meip_s, 3'd0, mtip_s, 7'd0};
      ADDR_MCYCLE:   csr_old_s = mcycle_r[31:0];
      ADDR_MCYCLEH:  csr_old_s = mcycle_r[63:32];
      default:       csr_old_s = 32'h0000_0000;
    endcase
  end

  // Read port: MRET shares the SYSTEM opcode, so it masks the decoder's read request.
  always_comb begin
    if (csr_re && !is_mret) begin
      csr_rdata = csr_old_s;
    end else begin
      csr_rdata = 32'h0000_0000;
    end
  end

  // Interrupt pending evaluation, trap vector and MRET decision.
  always_comb begin
    pend_e_s = mstatus_mie_r & meip_s & mie_meie_r;
    pend_t_s = mstatus_mie_r & mtip_s & mie_mtie_r;
    trap_s   = run_s & instr_valid & (pend_e_s | pend_t_s);
    mret_s   = run_s & instr_valid & is_mret & ~trap_s;
    if (pend_e_s) begin
      cause_s = CAUSE_EXT;
    end else begin
      cause_s = CAUSE_TMR;
    end
    if (mtvec_r[1:0] == 2'b01) begin
      evec_s = {mtvec_r[31:2], 2'b00} + {26'd0, cause_s, 2'b00};
    end else begin
      evec_s = {mtvec_r[31:2], 2'b00};
    end
  end

  // CSR write commit: set/clear with a zero mask is a pure read and writes nothing.
  always_comb begin
    csr_new_s = csr_alu(csr_op[1:0], csr_old_s, csr_wdata);
    case (csr_op[1:0])
      2'b01:   write_en_s = 1'b1;
      2'b10:   write_en_s = (csr_wdata != 32'h0000_0000);
      2'b11:   write_en_s = (csr_wdata != 32'h0000_0000);
      default: write_en_s = 1'b0;
    endcase
    commit_s = run_s & instr_valid & csr_we & ~is_mret & ~trap_s & write_en_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: one flush cycle after every redirect.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (trap_s || mret_s) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FLUSH: state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_RUN;
    endcase
  end

  // FSM output decode: instructions are only accepted in RUN.
  always_comb begin
    case (state_r)
      ST_RUN:   run_s = 1'b1;
      ST_FLUSH: run_s = 1'b0;
      default:  run_s = 1'b0;
    endcase
  end

  // Status, enable, vector, scratch, epc and cause registers; trap > MRET > write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mie_mtie_r     <= 1'b0;
      mie_meie_r     <= 1'b0;
      mtvec_r        <= MTVEC_RESET;
      mscratch_r     <= 32'h0000_0000;
      mepc_r         <= 32'h0000_0000;
      mcause_r       <= 32'h0000_0000;
    end else if (trap_s) begin
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
      mepc_r         <= {pc_wb[31:2], 2'b00};
      mcause_r       <= {1'b1, 27'd0, cause_s};
    end else if (mret_s) begin
      mstatus_mie_r  <= mstatus_mpie_r;
      mstatus_mpie_r <= 1'b1;
    end else if (commit_s) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie_r  <= csr_new_s[3];
          mstatus_mpie_r <= csr_new_s[7];
        end
        ADDR_MIE: begin
          mie_mtie_r <= csr_new_s[7];
          mie_meie_r <= csr_new_s[11];
        end
        ADDR_MTVEC:    mtvec_r    <= mtvec_legalize(csr_new_s);
        ADDR_MSCRATCH: mscratch_r <= csr_new_s;
        ADDR_MEPC:     mepc_r     <= {csr_new_s[31:2], 2'b00};
        ADDR_MCAUSE:   mcause_r   <= csr_new_s;
        default: begin
          mscratch_r <= mscratch_r;
        end
      endcase
    end else begin
      mscratch_r <= mscratch_r;
    end
  end

  // Free-running cycle counter; a write to either half replaces it and skips that increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcycle_r <= 64'd0;
    end else if (commit_s && (csr_addr == ADDR_MCYCLE)) begin
      mcycle_r <= {mcycle_r[63:32], csr_new_s};
    end else if (commit_s && (csr_addr == ADDR_MCYCLEH)) begin
      mcycle_r <= {csr_new_s, mcycle_r[31:0]};
    end else begin
      mcycle_r <= mcycle_r + 64'd1;
    end
  end

  // Registered redirect pulses and target; target is zero when no redirect is signalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_taken_r <= 1'b0;
      mret_taken_r <= 1'b0;
      epc_evec_r   <= 32'h0000_0000;
    end else begin
      trap_taken_r <= trap_s;
      mret_taken_r <= mret_s;
      if (trap_s) begin
        epc_evec_r <= evec_s;
      end else if (mret_s) begin
        epc_evec_r <= mepc_r;
      end else begin
        epc_evec_r <= 32'h0000_0000;
      end
    end
  end

  assign trap_taken = trap_taken_r;
  assign mret_taken = mret_taken_r;
  assign epc_evec   = epc_evec_r;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed, table-driven bench for csr_trap_unit with hand-written trap/MRET sequences.
module tb_csr_trap_unit;

  localparam logic [31:0] MTV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        csr_we;
  logic        csr_re;
  logic        is_mret;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] pc_wb;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic        trap_taken;
  logic        mret_taken;
  logic [31:0] epc_evec;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        iv;
    logic        we;
    logic        re;
    logic        mr;
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_trap;
    logic        exp_mret;
    logic [31:0] exp_evec;
  } vec_t;

  csr_trap_unit #(.MTVEC_RESET(MTV), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .csr_we(csr_we),
    .csr_re(csr_re), .is_mret(is_mret), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .pc_wb(pc_wb), .timer_irq(timer_irq), .ext_irq(ext_irq),
    .csr_rdata(csr_rdata), .trap_taken(trap_taken), .mret_taken(mret_taken),
    .epc_evec(epc_evec)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic iv, logic we, logic re, logic mr, logic [2:0] op,
                              logic [11:0] addr, logic [31:0] wd, logic [31:0] pc,
                              logic chk, logic [31:0] erd, logic et, logic em,
                              logic [31:0] ee);
    vec_t v;
    v.iv = iv; v.we = we; v.re = re; v.mr = mr; v.op = op; v.addr = addr;
    v.wdata = wd; v.pc = pc; v.chk_rd = chk; v.exp_rd = erd;
    v.exp_trap = et; v.exp_mret = em; v.exp_evec = ee;
    return v;
  endfunction

  function automatic vec_t rd(logic [11:0] addr, logic [31:0] erd);
    return mk(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, addr, 32'h0, 32'h0000_0400, 1'b1, erd,
              1'b0, 1'b0, 32'h0);
  endfunction

  function automatic vec_t wr(logic [2:0] op, logic [11:0] addr, logic [31:0] wd,
                              logic [31:0] erd);
    return mk(1'b1, 1'b1, 1'b1, 1'b0, op, addr, wd, 32'h0000_0400, 1'b1, erd,
              1'b0, 1'b0, 32'h0);
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector, check the combinational read, then the registered pulses.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    instr_valid = v.iv; csr_we = v.we; csr_re = v.re; is_mret = v.mr;
    csr_op = v.op; csr_addr = v.addr; csr_wdata = v.wdata; pc_wb = v.pc;
    #1;
    if (v.chk_rd) chk32({tag, " rdata"}, csr_rdata, v.exp_rd);
    @(posedge clk);
    #1;
    chk32({tag, " trap_taken"}, {31'd0, trap_taken}, {31'd0, v.exp_trap});
    chk32({tag, " mret_taken"}, {31'd0, mret_taken}, {31'd0, v.exp_mret});
    if (v.exp_trap || v.exp_mret) chk32({tag, " epc_evec"}, epc_evec, v.exp_evec);
  endtask

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; csr_we = 1'b0; csr_re = 1'b0; is_mret = 1'b0;
    csr_op = 3'b000; csr_addr = 12'h000; csr_wdata = 32'h0; pc_wb = 32'h0;
    timer_irq = 1'b0; ext_irq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk32("reset trap_taken", {31'd0, trap_taken}, 32'd0);
    chk32("reset mret_taken", {31'd0, mret_taken}, 32'd0);
    chk32("reset epc_evec", epc_evec, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values, read-then-write, set/clear semantics and field masking.
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 12'h340, 32'h0, 32'h0, 1'b1, 32'h0,
                     1'b0, 1'b0, 32'h0));
    tbl.push_back(rd(12'h300, 32'h0000_1800));
    tbl.push_back(rd(12'h304, 32'h0000_0000));
    tbl.push_back(rd(12'h305, MTV));
    tbl.push_back(wr(3'b001, 12'h340, 32'hDEAD_BEEF, 32'h0000_0000));
    tbl.push_back(rd(12'h340, 32'hDEAD_BEEF));
    tbl.push_back(wr(3'b010, 12'h340, 32'h0000_0000, 32'hDEAD_BEEF));
    tbl.push_back(rd(12'h340, 32'hDEAD_BEEF));
    tbl.push_back(wr(3'b011, 12'h340, 32'h0000_00EF, 32'hDEAD_BEEF));
    tbl.push_back(rd(12'h340, 32'hDEAD_BE00));
    tbl.push_back(wr(3'b110, 12'h340, 32'h0000_0011, 32'hDEAD_BE00));
    tbl.push_back(rd(12'h340, 32'hDEAD_BE11));
    tbl.push_back(wr(3'b001, 12'h305, 32'h0000_0103, MTV));
    tbl.push_back(rd(12'h305, 32'h0000_0100));
    tbl.push_back(wr(3'b001, 12'h341, 32'h0000_0043, 32'h0000_0000));
    tbl.push_back(rd(12'h341, 32'h0000_0040));
    tbl.push_back(wr(3'b001, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800));
    tbl.push_back(rd(12'h300, 32'h0000_1888));
    tbl.push_back(wr(3'b001, 12'h304, 32'hFFFF_FFFF, 32'h0000_0000));
    tbl.push_back(rd(12'h304, 32'h0000_0880));
    tbl.push_back(rd(12'h344, 32'h0000_0000));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 12'h340, 32'h0, 32'h400, 1'b1, 32'h0,
                     1'b0, 1'b0, 32'h0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 12'h340, 32'h0, 32'h400, 1'b1,
                     32'hDEAD_BE11, 1'b0, 1'b0, 32'h0));
    tbl.push_back(rd(12'h340, 32'hDEAD_BE11));
    tbl.push_back(wr(3'b001, 12'h7C0, 32'h0000_0005, 32'h0000_0000));
    tbl.push_back(rd(12'h7C0, 32'h0000_0000));
    tbl.push_back(wr(3'b101, 12'h342, 32'h1234_5678, 32'h0000_0000));
    tbl.push_back(rd(12'h342, 32'h1234_5678));

    foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

    // Timer trap through the synchronizer, then an MRET in the flush cycle.
    step(wr(3'b001, 12'h304, 32'h0000_0080, 32'h0000_0880), "mie_t");
    timer_irq = 1'b1;
    step(mk(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 12'h344, 32'h0, 32'h500, 1'b1, 32'h0,
            1'b0, 1'b0, 32'h0), "t_sync0");
    step(mk(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 12'h344, 32'h0, 32'h504, 1'b1, 32'h0,
            1'b0, 1'b0, 32'h0), "t_sync1");
    step(mk(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 12'h344, 32'h0, 32'h510, 1'b1, 32'h80,
            1'b1, 1'b0, 32'h100), "t_trap");
    step(mk(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 12'h342, 32'h0, 32'h514, 1'b1, 32'h0,
            1'b0, 1'b0, 32'h0), "flush_mret");
    timer_irq = 1'b0;
    step(rd(12'h342, 32'h8000_0007), "t_mcause");
    step(rd(12'h341, 32'h0000_0510), "t_mepc");
    step(rd(12'h300, 32'h0000_1880), "t_mstatus");

    // MRET with a simultaneous write request that must not commit.
    step(wr(3'b001, 12'h341, 32'h0000_0040, 32'h0000_0510), "mepc40");
    step(mk(1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 12'h340, 32'h0, 32'h520, 1'b1, 32'h0,
            1'b0, 1'b1, 32'h40), "mret");
    step(rd(12'h340, 32'hDEAD_BE11), "mret_nowr");
    step(rd(12'h300, 32'h0000_1888), "mret_mie");

    // Vectored mode, both interrupts: external wins, same-cycle CSRRW is dropped.
    step(wr(3'b001, 12'h305, 32'h0000_0201, 32'h0000_0100), "mtvec_v");
    step(wr(3'b001, 12'h304, 32'h0000_0880, 32'h0000_0080), "mie_both");
    timer_irq = 1'b1; ext_irq = 1'b1;
    step(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0, 32'h600, 1'b0, 32'h0,
            1'b0, 1'b0, 32'h0), "b_sync0");
    step(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 12'h0, 32'h0, 32'h604, 1'b0, 32'h0,
            1'b0, 1'b0, 32'h0), "b_sync1");
    step(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 12'h340, 32'h5555_5555, 32'h608, 1'b1,
            32'hDEAD_BE11, 1'b1, 1'b0, 32'h22C), "b_trap");
    step(rd(12'h342, 32'h8000_000B), "b_mcause");
    timer_irq = 1'b0; ext_irq = 1'b0;
    step(rd(12'h340, 32'hDEAD_BE11), "b_nowr");
    step(rd(12'h341, 32'h0000_0608), "b_mepc");

    // mcycle wrap and zero-mask set still counting.
    step(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 12'hB00, 32'hFFFF_FFFF, 32'h400, 1'b0, 32'h0,
            1'b0, 1'b0, 32'h0), "cyc_wlo");
    step(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 12'hB80, 32'hFFFF_FFFF, 32'h400, 1'b0, 32'h0,
            1'b0, 1'b0, 32'h0), "cyc_whi");
    step(rd(12'hB00, 32'hFFFF_FFFF), "cyc_pre");
    step(rd(12'hB00, 32'h0000_0000), "cyc_wrap_lo");
    step(rd(12'hB80, 32'h0000_0000), "cyc_wrap_hi");
    step(wr(3'b010, 12'hB00, 32'h0000_0000, 32'h0000_0002), "cyc_rs0");
    step(rd(12'hB00, 32'h0000_0003), "cyc_inc");

    // Reset asserted during the flush cycle after an MRET.
    step(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 12'h0, 32'h0, 32'h700, 1'b0, 32'h0,
            1'b0, 1'b1, 32'h608), "mret2");
    rst_n = 1'b0;
    step(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 12'h0, 32'h0, 32'h704, 1'b0, 32'h0,
            1'b0, 1'b0, 32'h0), "rst_flush");
    chk32("rst_flush epc_evec", epc_evec, 32'h0);
    rst_n = 1'b1;
    step(rd(12'h305, MTV), "rst_mtvec");
    step(rd(12'h340, 32'h0000_0000), "rst_mscratch");
    step(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 12'h0, 32'h0, 32'h800, 1'b0, 32'h0,
            1'b0, 1'b1, 32'h0), "rst_run_mret");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
